// File: rtl/watch_pkg.sv
// Shared encodings for the watch edit/adjust controller: field codes, ASCII
// command bytes, parser states and the single-byte edit operations.
package watch_pkg;

   localparam logic [1:0] FIELD_SEC  = 2'd0;
   localparam logic [1:0] FIELD_MIN  = 2'd1;
   localparam logic [1:0] FIELD_HOUR = 2'd2;

   localparam logic [7:0] ASC_U_UP = 8'h55;
   localparam logic [7:0] ASC_U_LO = 8'h75;
   localparam logic [7:0] ASC_D_UP = 8'h44;
   localparam logic [7:0] ASC_D_LO = 8'h64;
   localparam logic [7:0] ASC_L_UP = 8'h4C;
   localparam logic [7:0] ASC_L_LO = 8'h6C;
   localparam logic [7:0] ASC_R_UP = 8'h52;
   localparam logic [7:0] ASC_R_LO = 8'h72;
   localparam logic [7:0] ASC_T    = 8'h54;
   localparam logic [7:0] ASC_0    = 8'h30;
   localparam logic [7:0] ASC_9    = 8'h39;

   typedef enum logic [2:0] {
      PS_IDLE = 3'd0,
      PS_H10  = 3'd1,
      PS_H1   = 3'd2,
      PS_M10  = 3'd3,
      PS_M1   = 3'd4,
      PS_S10  = 3'd5,
      PS_S1   = 3'd6
   } parse_state_t;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_UP    = 3'd1,
      OP_DOWN  = 3'd2,
      OP_LEFT  = 3'd3,
      OP_RIGHT = 3'd4
   } edit_op_t;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASC_0) && (b <= ASC_9);
   endfunction

   function automatic edit_op_t decode_uart_op(input logic [7:0] b);
      edit_op_t op;
      case (b)
         ASC_U_UP, ASC_U_LO: op = OP_UP;
         ASC_D_UP, ASC_D_LO: op = OP_DOWN;
         ASC_L_UP, ASC_L_LO: op = OP_LEFT;
         ASC_R_UP, ASC_R_LO: op = OP_RIGHT;
         default:            op = OP_NONE;
      endcase
      return op;
   endfunction

   // Field codes above HOUR are never produced; treat them as HOUR when wrapping.
   function automatic logic [1:0] field_higher(input logic [1:0] f);
      return (f >= FIELD_HOUR) ? FIELD_SEC : f + 2'd1;
   endfunction

   function automatic logic [1:0] field_lower(input logic [1:0] f);
      return (f == FIELD_SEC) ? FIELD_HOUR :
             (f > FIELD_HOUR) ? FIELD_MIN  : f - 2'd1;
   endfunction

   function automatic parse_state_t parse_advance(input parse_state_t s);
      parse_state_t n;
      case (s)
         PS_H10:  n = PS_H1;
         PS_H1:   n = PS_M10;
         PS_M10:  n = PS_M1;
         PS_M1:   n = PS_S10;
         PS_S10:  n = PS_S1;
         default: n = PS_IDLE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/watch_time_parser.sv
// "T"+HHMMSS command parser: collects six ASCII digits, range-checks the
// result and emits either a one-cycle load strobe or a one-cycle error strobe.
module watch_time_parser
   import watch_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic       parser_idle,
   output logic       load_en,
   output logic [4:0] load_hour,
   output logic [5:0] load_min,
   output logic [5:0] load_sec,
   output logic       cmd_err
);

   localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   parse_state_t     state_r, state_nxt_s;
   logic [3:0]       h10_r, h1_r, m10_r, m1_r, s10_r;
   logic [CNT_W-1:0] cnt_r;
   logic             load_en_r, cmd_err_r;
   logic [4:0]       load_hour_r;
   logic [5:0]       load_min_r, load_sec_r;

   logic             digit_ok_s, load_now_s, err_now_s, range_ok_s;
   logic [3:0]       digit_s;
   logic [6:0]       hour_s, min_s, sec_s;

   assign digit_ok_s = is_digit(rx_data);
   assign digit_s    = rx_data[3:0];
   assign hour_s     = ({3'd0, h10_r} * 7'd10) + {3'd0, h1_r};
   assign min_s      = ({3'd0, m10_r} * 7'd10) + {3'd0, m1_r};
   assign sec_s      = ({3'd0, s10_r} * 7'd10) + {3'd0, digit_s};
   assign range_ok_s = (hour_s <= 7'd23) && (min_s <= 7'd59) && (sec_s <= 7'd59);

   // Next-state and strobe decision for the T-sequence.
   always_comb begin
      state_nxt_s = state_r;
      load_now_s  = 1'b0;
      err_now_s   = 1'b0;
      if (state_r == PS_IDLE) begin
         if (rx_done && (rx_data == ASC_T)) begin
            state_nxt_s = PS_H10;
         end else begin
            state_nxt_s = PS_IDLE;
         end
      end else if (rx_done) begin
         if (!digit_ok_s) begin
            state_nxt_s = PS_IDLE;
            err_now_s   = 1'b1;
         end else if (state_r == PS_S1) begin
            state_nxt_s = PS_IDLE;
            load_now_s  = range_ok_s;
            err_now_s   = !range_ok_s;
         end else begin
            state_nxt_s = parse_advance(state_r);
         end
      end else if (cnt_r == CNT_MAX) begin
         state_nxt_s = PS_IDLE;
         err_now_s   = 1'b1;
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State, idle counter and registered strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= PS_IDLE;
         cnt_r     <= '0;
         load_en_r <= 1'b0;
         cmd_err_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= ((state_r == PS_IDLE) || rx_done) ? '0 : cnt_r + CNT_W'(1);
         load_en_r <= load_now_s;
         cmd_err_r <= err_now_s;
      end
   end

   // Partial digit capture; contents are don't-care outside a sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         h10_r <= 4'd0;
         h1_r  <= 4'd0;
         m10_r <= 4'd0;
         m1_r  <= 4'd0;
         s10_r <= 4'd0;
      end else if (rx_done && digit_ok_s) begin
         case (state_r)
            PS_H10:  h10_r <= digit_s;
            PS_H1:   h1_r  <= digit_s;
            PS_M10:  m10_r <= digit_s;
            PS_M1:   m1_r  <= digit_s;
            PS_S10:  s10_r <= digit_s;
            default: h10_r <= h10_r;
         endcase
      end
   end

   // Loaded time is held until the next successful sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         load_hour_r <= 5'd0;
         load_min_r  <= 6'd0;
         load_sec_r  <= 6'd0;
      end else if (load_now_s) begin
         load_hour_r <= hour_s[4:0];
         load_min_r  <= min_s[5:0];
         load_sec_r  <= sec_s[5:0];
      end
   end

   assign parser_idle = (state_r == PS_IDLE);
   assign load_en     = load_en_r;
   assign cmd_err     = cmd_err_r;
   assign load_hour   = load_hour_r;
   assign load_min    = load_min_r;
   assign load_sec    = load_sec_r;

endmodule

// File: rtl/watch_adjust_ctrl.sv
// Watch edit controller: merges buttons and UART single-byte ops into field
// select and inc/dec strobes, and hosts the T-sequence time parser.
module watch_adjust_ctrl
   import watch_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 100_000_000,
   parameter logic [1:0]  FIELD_RST   = 2'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       sw,
   input  logic [7:0] uart_rx,
   input  logic       uart_rx_done,
   output logic [1:0] field_sel,
   output logic       inc_pulse,
   output logic       dec_pulse,
   output logic       load_en,
   output logic [4:0] load_hour,
   output logic [5:0] load_min,
   output logic [5:0] load_sec,
   output logic       edit_active,
   output logic       cmd_err
);

   logic [1:0] field_r, field_nxt_s;
   logic       inc_r, dec_r, edit_r;
   edit_op_t   pend_r, pend_nxt_s, uart_op_s, issue_s;
   logic       parser_idle_s, btn_any_s;
   logic       do_up_s, do_down_s, do_left_s, do_right_s;

   watch_time_parser #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_parser (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (uart_rx),
      .rx_done     (uart_rx_done),
      .parser_idle (parser_idle_s),
      .load_en     (load_en),
      .load_hour   (load_hour),
      .load_min    (load_min),
      .load_sec    (load_sec),
      .cmd_err     (cmd_err)
   );

   assign btn_any_s = btn_up | btn_down | btn_left | btn_right;
   assign uart_op_s = (uart_rx_done && parser_idle_s) ? decode_uart_op(uart_rx) : OP_NONE;

   // Arbitration: buttons win, a deferred UART op waits in the pending slot.
   always_comb begin
      pend_nxt_s = pend_r;
      issue_s    = OP_NONE;
      do_up_s    = 1'b0;
      do_down_s  = 1'b0;
      do_left_s  = 1'b0;
      do_right_s = 1'b0;
      if (!sw) begin
         pend_nxt_s = OP_NONE;
      end else if (btn_any_s) begin
         do_up_s    = btn_up;
         do_down_s  = btn_down;
         do_left_s  = btn_left;
         do_right_s = btn_right;
         pend_nxt_s = (uart_op_s != OP_NONE) ? uart_op_s : pend_r;
      end else begin
         // A fresh byte supersedes anything still pending.
         issue_s    = (uart_op_s != OP_NONE) ? uart_op_s : pend_r;
         pend_nxt_s = OP_NONE;
         do_up_s    = (issue_s == OP_UP);
         do_down_s  = (issue_s == OP_DOWN);
         do_left_s  = (issue_s == OP_LEFT);
         do_right_s = (issue_s == OP_RIGHT);
      end
   end

   // Field wrap; opposing directions cancel.
   always_comb begin
      field_nxt_s = field_r;
      if (do_left_s && !do_right_s) begin
         field_nxt_s = field_higher(field_r);
      end else if (do_right_s && !do_left_s) begin
         field_nxt_s = field_lower(field_r);
      end else begin
         field_nxt_s = field_r;
      end
   end

   // Registered field, strobes, pending slot and edit flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         field_r <= FIELD_RST;
         inc_r   <= 1'b0;
         dec_r   <= 1'b0;
         edit_r  <= 1'b0;
         pend_r  <= OP_NONE;
      end else begin
         field_r <= field_nxt_s;
         inc_r   <= do_up_s & ~do_down_s;
         dec_r   <= do_down_s & ~do_up_s;
         edit_r  <= sw;
         pend_r  <= pend_nxt_s;
      end
   end

   assign field_sel   = field_r;
   assign inc_pulse   = inc_r;
   assign dec_pulse   = dec_r;
   assign edit_active = edit_r;

endmodule

// File: tb/tb_watch_adjust_ctrl.sv
// Directed bench for watch_adjust_ctrl: field wrap, arbitration, gating,
// T-sequence load, error paths and timeout (TIMEOUT_CYC shortened to 50).
module tb_watch_adjust_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       sw = 1'b0;
   logic [7:0] uart_rx = 8'h00;
   logic       uart_rx_done = 1'b0;
   logic [1:0] field_sel;
   logic       inc_pulse, dec_pulse, load_en, edit_active, cmd_err;
   logic [4:0] load_hour;
   logic [5:0] load_min, load_sec;

   int n_vec = 0;
   int n_err = 0;

   watch_adjust_ctrl #(.TIMEOUT_CYC(50), .FIELD_RST(2'd0)) dut (
      .clk(clk), .rst(rst),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .sw(sw), .uart_rx(uart_rx), .uart_rx_done(uart_rx_done),
      .field_sel(field_sel), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
      .load_en(load_en), .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
      .edit_active(edit_active), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic press(input logic u, input logic d, input logic l, input logic r);
      btn_up = u; btn_down = d; btn_left = l; btn_right = r;
      @(negedge clk);
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      uart_rx = b; uart_rx_done = 1'b1;
      @(negedge clk);
      uart_rx_done = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(8'(s[i]));
   endtask

   initial begin
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst_field", 8'(field_sel), 8'd0);
      check("rst_inc", 8'(inc_pulse), 8'd0);
      check("rst_dec", 8'(dec_pulse), 8'd0);
      check("rst_load_en", 8'(load_en), 8'd0);
      check("rst_load_hour", 8'(load_hour), 8'd0);
      check("rst_edit", 8'(edit_active), 8'd0);
      check("rst_err", 8'(cmd_err), 8'd0);

      // 1: left wraps 0->1->2->0
      sw = 1'b1;
      tick();
      check("edit_on", 8'(edit_active), 8'd1);
      press(1'b0, 1'b0, 1'b1, 1'b0); check("left1", 8'(field_sel), 8'd1);
      press(1'b0, 1'b0, 1'b1, 1'b0); check("left2", 8'(field_sel), 8'd2);
      press(1'b0, 1'b0, 1'b1, 1'b0); check("left3", 8'(field_sel), 8'd0);
      press(1'b0, 1'b0, 1'b0, 1'b1); check("right_wrap", 8'(field_sel), 8'd2);
      press(1'b0, 1'b0, 1'b1, 1'b1); check("lr_conflict", 8'(field_sel), 8'd2);
      send(8'h6C);                   check("uart_l_wrap", 8'(field_sel), 8'd0);
      press(1'b1, 1'b1, 1'b0, 1'b0);
      check("ud_inc", 8'(inc_pulse), 8'd0);
      check("ud_dec", 8'(dec_pulse), 8'd0);

      // 2: button beats UART in the same cycle, UART op follows one cycle later
      btn_up = 1'b1; uart_rx = 8'h64; uart_rx_done = 1'b1;
      tick();
      btn_up = 1'b0; uart_rx_done = 1'b0;
      check("arb_inc_p1", 8'(inc_pulse), 8'd1);
      check("arb_dec_p1", 8'(dec_pulse), 8'd0);
      tick();
      check("arb_inc_p2", 8'(inc_pulse), 8'd0);
      check("arb_dec_p2", 8'(dec_pulse), 8'd1);
      tick();
      check("arb_dec_p3", 8'(dec_pulse), 8'd0);

      // 3: sw=0 discards both sources
      sw = 1'b0;
      btn_up = 1'b1; uart_rx = 8'h75; uart_rx_done = 1'b1;
      tick();
      btn_up = 1'b0; uart_rx_done = 1'b0;
      check("gate_inc", 8'(inc_pulse), 8'd0);
      check("gate_edit", 8'(edit_active), 8'd0);
      tick();
      check("gate_inc_late", 8'(inc_pulse), 8'd0);
      check("gate_dec_late", 8'(dec_pulse), 8'd0);
      sw = 1'b1;
      tick();

      // 4: valid full-time load
      send_str("T23595");
      check("load_early", 8'(load_en), 8'd0);
      send(8'h39);
      check("load_en", 8'(load_en), 8'd1);
      check("load_hour", 8'(load_hour), 8'd23);
      check("load_min", 8'(load_min), 8'd59);
      check("load_sec", 8'(load_sec), 8'd59);
      check("load_noerr", 8'(cmd_err), 8'd0);
      tick();
      check("load_en_drop", 8'(load_en), 8'd0);
      check("load_hold", 8'(load_hour), 8'd23);

      // 5: out-of-range hour, then non-digit mid-sequence
      send_str("T246000");
      check("range_err", 8'(cmd_err), 8'd1);
      check("range_noload", 8'(load_en), 8'd0);
      check("range_keep", 8'(load_hour), 8'd23);
      tick();
      check("range_err_drop", 8'(cmd_err), 8'd0);
      send_str("T1");
      check("nd_err_early", 8'(cmd_err), 8'd0);
      send(8'h78);
      check("nondigit_err", 8'(cmd_err), 8'd1);
      send(8'h75);
      check("idle_after_err", 8'(inc_pulse), 8'd1);

      // 6: timeout after 50 idle clocks, then single-byte ops decode again
      send_str("T12");
      repeat (49) tick();
      check("timeout_early", 8'(cmd_err), 8'd0);
      tick();
      check("timeout_err", 8'(cmd_err), 8'd1);
      tick();
      check("timeout_drop", 8'(cmd_err), 8'd0);
      send(8'h75);
      check("post_timeout_inc", 8'(inc_pulse), 8'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
